// File: rtl/arb_req_queue_pkg.sv
// Shared types and default widths for the two-client arbiter request queue.
package arb_pkg;

   typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} arb_src_e;

   localparam int unsigned ARB_DW_DEFAULT    = 8;
   localparam int unsigned ARB_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/arb_req_fifo.sv
// Per-client FIFO: a push is accepted when there is room, or when full and popping the same cycle.
module arb_req_fifo
   import arb_pkg::*;
#(
   parameter int unsigned DW    = ARB_DW_DEFAULT,
   parameter int unsigned DEPTH = ARB_DEPTH_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [DW-1:0]          din,
   input  logic                   pop,
   output logic [DW-1:0]          dout,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   ovf
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;
   assign dout  = mem_q[rd_ptr_q];

   // Pointer/count next state; a full FIFO that pops this cycle frees a slot for the push.
   always_comb begin
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      ovf      = push & full & ~do_pop;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage carries no reset: contents are only observed behind a non-zero count.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/arb_req_queue.sv
// Two-client request buffer feeding the arbiter: raises reqN while FIFO N holds data,
// pops the granted head and forwards it one cycle later with its source id.
module arb_req_queue
   import arb_pkg::*;
#(
   parameter int unsigned DW    = ARB_DW_DEFAULT,
   parameter int unsigned DEPTH = ARB_DEPTH_DEFAULT
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push0,
   input  logic [DW-1:0] data0,
   output logic          full0,
   input  logic          push1,
   input  logic [DW-1:0] data1,
   output logic          full1,
   output logic          req0,
   output logic          req1,
   input  logic          gnt0,
   input  logic          gnt1,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_src,
   output logic          err
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [DW-1:0] dout0, dout1;
   logic [CW-1:0] count0, count1;
   logic          empty0, empty1;
   logic          ovf0, ovf1;
   logic          pop0_c, pop1_c, gnt_conflict_c, gnt_idle_c;

   logic          valid_q, valid_d;
   logic [DW-1:0] data_q, data_d;
   arb_src_e      src_q, src_d;
   logic          err_q, err_d;

   assign req0 = (count0 != '0);
   assign req1 = (count1 != '0);

   // Grant decode: a double grant pops nothing; a grant to an empty client is ignored.
   assign gnt_conflict_c = gnt0 & gnt1;
   assign gnt_idle_c     = (gnt0 & empty0) | (gnt1 & empty1);
   assign pop0_c         = gnt0 & req0 & ~gnt_conflict_c;
   assign pop1_c         = gnt1 & req1 & ~gnt_conflict_c;

   arb_req_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
      .clk   (clk),
      .rst   (rst),
      .push  (push0),
      .din   (data0),
      .pop   (pop0_c),
      .dout  (dout0),
      .count (count0),
      .full  (full0),
      .empty (empty0),
      .ovf   (ovf0)
   );

   arb_req_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
      .clk   (clk),
      .rst   (rst),
      .push  (push1),
      .din   (data1),
      .pop   (pop1_c),
      .dout  (dout1),
      .count (count1),
      .full  (full1),
      .empty (empty1),
      .ovf   (ovf1)
   );

   // Output stage holds the last payload/source when nothing is popped.
   always_comb begin
      valid_d = 1'b0;
      data_d  = data_q;
      src_d   = src_q;
      err_d   = err_q | gnt_conflict_c | gnt_idle_c | ovf0 | ovf1;
      if (pop0_c) begin
         valid_d = 1'b1;
         data_d  = dout0;
         src_d   = SRC0;
      end else if (pop1_c) begin
         valid_d = 1'b1;
         data_d  = dout1;
         src_d   = SRC1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         src_q   <= SRC0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         src_q   <= src_d;
         err_q   <= err_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_src   = src_q;
   assign err       = err_q;

endmodule

// File: tb/tb_arb_req_queue.sv
// Scoreboard bench for arb_req_queue: queue-based client model, randomized grants and pushes.
module tb_arb_req_queue;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;

   logic          clk, rst;
   logic          push0, push1, gnt0, gnt1;
   logic [DW-1:0] data0, data1;
   logic          full0, full1, req0, req1, out_valid, out_src, err;
   logic [DW-1:0] out_data;

   typedef struct packed {
      logic          src;
      logic [DW-1:0] data;
   } exp_t;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] mq0[$];
   logic [DW-1:0] mq1[$];
   exp_t          sb[$];
   logic          m_err;
   logic [DW-1:0] exp_last_data;
   logic          exp_last_src;

   arb_req_queue #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .push0     (push0),
      .data0     (data0),
      .full0     (full0),
      .push1     (push1),
      .data1     (data1),
      .full1     (full1),
      .req0      (req0),
      .req1      (req1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_src   (out_src),
      .err       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      chk("req0", 32'(req0), 32'(mq0.size() != 0));
      chk("req1", 32'(req1), 32'(mq1.size() != 0));
      chk("full0", 32'(full0), 32'(mq0.size() == DEPTH));
      chk("full1", 32'(full1), 32'(mq1.size() == DEPTH));
      chk("err", 32'(err), 32'(m_err));
   endtask

   // One clock of stimulus; the model applies the same cycle's rules from its queues.
   task automatic cycle(input logic p0, input logic [DW-1:0] d0,
                        input logic p1, input logic [DW-1:0] d1,
                        input logic g0, input logic g1);
      logic r0, r1, pp0, pp1, acc0, acc1;
      exp_t e;
      @(negedge clk);
      check_state();
      push0 = p0; data0 = d0; push1 = p1; data1 = d1; gnt0 = g0; gnt1 = g1;
      r0   = (mq0.size() != 0);
      r1   = (mq1.size() != 0);
      pp0  = g0 && r0 && !g1;
      pp1  = g1 && r1 && !g0;
      acc0 = p0 && ((mq0.size() < DEPTH) || pp0);
      acc1 = p1 && ((mq1.size() < DEPTH) || pp1);
      if ((g0 && g1) || (g0 && !r0) || (g1 && !r1)) m_err = 1'b1;
      if ((p0 && !acc0) || (p1 && !acc1)) m_err = 1'b1;
      if (pp0) begin
         e.src = 1'b0; e.data = mq0.pop_front(); sb.push_back(e);
      end
      if (pp1) begin
         e.src = 1'b1; e.data = mq1.pop_front(); sb.push_back(e);
      end
      if (acc0) mq0.push_back(d0);
      if (acc1) mq1.push_back(d1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   // Reset is raised between edges so its asynchronous effect is checked immediately.
   task automatic do_reset();
      @(negedge clk);
      #2;
      push0 = 1'b0; push1 = 1'b0; gnt0 = 1'b0; gnt1 = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst req0", 32'(req0), 32'd0);
      chk("rst req1", 32'(req1), 32'd0);
      chk("rst full0", 32'(full0), 32'd0);
      chk("rst full1", 32'(full1), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_data", 32'(out_data), 32'd0);
      chk("rst out_src", 32'(out_src), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      mq0.delete(); mq1.delete(); sb.delete();
      m_err = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every pop must surface exactly one cycle later; otherwise outputs hold.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            exp_last_data = '0;
            exp_last_src  = 1'b0;
         end else begin
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
               e = sb.pop_front();
               if (out_valid) begin
                  chk("out_data", 32'(out_data), 32'(e.data));
                  chk("out_src", 32'(out_src), 32'(e.src));
               end
               exp_last_data = e.data;
               exp_last_src  = e.src;
            end else if (!out_valid) begin
               chk("out_data hold", 32'(out_data), 32'(exp_last_data));
               chk("out_src hold", 32'(out_src), 32'(exp_last_src));
            end
         end
      end
   end

   initial begin
      logic          p0, p1, g0, g1;
      logic [DW-1:0] d0, d1;
      int            r;
      rst = 1'b1;
      push0 = 1'b0; push1 = 1'b0; gnt0 = 1'b0; gnt1 = 1'b0;
      data0 = '0; data1 = '0;
      m_err = 1'b0;
      exp_last_data = '0; exp_last_src = 1'b0;
      do_reset();

      // Mid-stream reset drops three buffered entries.
      for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h10 + i), 1'b0, '0, 1'b0, 1'b0);
      do_reset();
      idle(2);

      // Basic two-entry transfer on client 0.
      cycle(1'b1, 8'hA1, 1'b0, '0, 1'b0, 1'b0);
      cycle(1'b1, 8'hA2, 1'b0, '0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      idle(2);

      // Overfill client 1, then refill across the pointer wrap.
      for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, DW'(8'hB0 + i), 1'b0, 1'b0);
      idle(1);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, DW'(8'hC0 + i), 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      idle(2);

      // Full FIFO with simultaneous push and pop keeps err clear.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'hD0 + i), 1'b0, '0, 1'b0, 1'b0);
      cycle(1'b1, 8'h55, 1'b0, '0, 1'b1, 1'b0);
      idle(1);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      idle(2);

      // Alternating grants.
      cycle(1'b1, 8'hE0, 1'b1, 8'hF0, 1'b0, 1'b0);
      cycle(1'b1, 8'hE1, 1'b1, 8'hF1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      idle(2);

      // Protocol errors: double grant, then grant to an empty client.
      cycle(1'b1, 8'h31, 1'b1, 8'h41, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
      idle(1);
      cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      idle(2);

      // Randomized traffic with occasional resets.
      do_reset();
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 99) == 0) do_reset();
         p0 = ($urandom_range(0, 1) == 1);
         p1 = ($urandom_range(0, 1) == 1);
         d0 = DW'($urandom);
         d1 = DW'($urandom);
         r  = $urandom_range(0, 15);
         g0 = 1'b0; g1 = 1'b0;
         if (r < 10) begin
            if ($urandom_range(0, 1) == 0) g0 = (mq0.size() != 0);
            else                           g1 = (mq1.size() != 0);
         end else if (r >= 13) begin
            g0 = ($urandom_range(0, 1) == 1);
            g1 = ($urandom_range(0, 1) == 1);
         end
         cycle(p0, d0, p1, d1, g0, g1);
      end
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
